// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the CPU instruction/data memory arbiter.
package mem_arbiter_pkg;

    // Arbiter FSM encoding, kept as plain constants for legacy tools.
    localparam logic [1:0] ARB_IDLE   = 2'd0;
    localparam logic [1:0] ARB_BUSY_I = 2'd1;
    localparam logic [1:0] ARB_BUSY_D = 2'd2;

    // A data-port access is pending on a read or on any byte write enable.
    function automatic logic is_d_request(input logic rd, input logic [3:0] we);
        return rd | (|we);
    endfunction

endpackage

// File: rtl/mem_arbiter_timeout.sv
// Bus watchdog: counts BUSY cycles without an ack and flags the abort cycle.
module arb_timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // The abort happens at the end of the TIMEOUT-th waiting cycle, i.e. when
    // the count of already-waited cycles equals TIMEOUT-1.
    localparam logic [CW-1:0] LIMIT = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // Count waiting cycles since the last grant, holding at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != LIMIT)) begin
            count <= count + CW'(1);
        end
    end

    // en already excludes ack cycles, so a same-cycle ack always wins.
    assign expired = (TIMEOUT != 0) && en && (count == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory bus between CPU instruction-fetch and data ports.
// Data wins by default; a streak limit guarantees fetch progress; a watchdog
// aborts accesses that never receive an ack.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic [31:0]       o_data_i,
    output logic              o_valid_i,
    input  logic              i_rd_d,
    input  logic [3:0]        i_we_d,
    input  logic [ADDR_W-1:0] i_addr_d,
    input  logic [31:0]       i_data_d,
    output logic [31:0]       o_data_d,
    output logic              o_valid_d,
    output logic              o_err,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [3:0]        o_mem_we,
    output logic [31:0]       o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [31:0]       i_mem_rdata
);

    localparam int SW = (MAX_D_STREAK < 2) ? 1 : $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    logic [1:0]    state;
    logic [SW-1:0] streak;
    logic          d_req;
    logic          bubble;
    logic          busy;
    logic          grant_i;
    logic          grant_d;
    logic          expired;

    assign d_req  = is_d_request(i_rd_d, i_we_d);
    // The cycle carrying a valid pulse is a forced IDLE bubble: the requester
    // still shows its finished request, which must not be granted again.
    assign bubble = o_valid_i | o_valid_d;
    assign busy   = (state == ARB_BUSY_I) || (state == ARB_BUSY_D);

    // Pick the winner while idle: data first unless it has hit its streak limit.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if ((state == ARB_IDLE) && !bubble) begin
            if (d_req && (!i_req_i || (streak != STREAK_MAX))) begin
                grant_d = 1'b1;
            end else if (i_req_i) begin
                grant_i = 1'b1;
            end
        end
    end

    arb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (i_clk),
        .rst     (i_rst),
        .clr     (grant_i | grant_d),
        .en      (busy & ~i_mem_ack),
        .expired (expired)
    );

    // Track consecutive data grants that made a pending fetch wait.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            streak <= '0;
        end else if (grant_i) begin
            streak <= '0;
        end else if (grant_d) begin
            if (!i_req_i) begin
                streak <= '0;
            end else if (streak != STREAK_MAX) begin
                streak <= streak + SW'(1);
            end
        end
    end

    // Main FSM: launch the granted access, hold the bus, then return the result.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= ARB_IDLE;
            o_mem_req   <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_we    <= '0;
            o_mem_wdata <= '0;
            o_data_i    <= '0;
            o_data_d    <= '0;
            o_valid_i   <= 1'b0;
            o_valid_d   <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            o_valid_i <= 1'b0;
            o_valid_d <= 1'b0;
            o_err     <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (grant_d) begin
                        state       <= ARB_BUSY_D;
                        o_mem_req   <= 1'b1;
                        o_mem_addr  <= i_addr_d;
                        o_mem_we    <= i_we_d;
                        o_mem_wdata <= i_data_d;
                    end else if (grant_i) begin
                        state       <= ARB_BUSY_I;
                        o_mem_req   <= 1'b1;
                        o_mem_addr  <= i_addr_i;
                        o_mem_we    <= '0;
                        o_mem_wdata <= '0;
                    end
                end
                ARB_BUSY_I, ARB_BUSY_D: begin
                    if (i_mem_ack) begin
                        state     <= ARB_IDLE;
                        o_mem_req <= 1'b0;
                        if (state == ARB_BUSY_I) begin
                            o_data_i  <= i_mem_rdata;
                            o_valid_i <= 1'b1;
                        end else begin
                            if (o_mem_we == 4'b0000) begin
                                o_data_d <= i_mem_rdata;
                            end
                            o_valid_d <= 1'b1;
                        end
                    end else if (expired) begin
                        state     <= ARB_IDLE;
                        o_mem_req <= 1'b0;
                        o_err     <= 1'b1;
                        if (state == ARB_BUSY_I) begin
                            o_data_i  <= '0;
                            o_valid_i <= 1'b1;
                        end else begin
                            o_data_d  <= '0;
                            o_valid_d <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= ARB_IDLE;
                    o_mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int MAX_D  = 4;
    localparam int TMO    = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_i;
    logic [31:0] i_addr_i;
    logic [31:0] o_data_i;
    logic        o_valid_i;
    logic        i_rd_d;
    logic [3:0]  i_we_d;
    logic [31:0] i_addr_d;
    logic [31:0] i_data_d;
    logic [31:0] o_data_d;
    logic        o_valid_d;
    logic        o_err;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic [3:0]  o_mem_we;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W       (ADDR_W),
        .MAX_D_STREAK (MAX_D),
        .TIMEOUT      (TMO)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_i     (i_req_i),
        .i_addr_i    (i_addr_i),
        .o_data_i    (o_data_i),
        .o_valid_i   (o_valid_i),
        .i_rd_d      (i_rd_d),
        .i_we_d      (i_we_d),
        .i_addr_d    (i_addr_d),
        .i_data_d    (i_data_d),
        .o_data_d    (o_data_d),
        .o_valid_d   (o_valid_d),
        .o_err       (o_err),
        .o_mem_req   (o_mem_req),
        .o_mem_addr  (o_mem_addr),
        .o_mem_we    (o_mem_we),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_ack   (i_mem_ack),
        .i_mem_rdata (i_mem_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req_i = 0; i_addr_i = 0; i_rd_d = 0; i_we_d = 0; i_addr_d = 0; i_data_d = 0;
        i_mem_ack = 0; i_mem_rdata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1; tick(); tick(); rst = 0; tick();
    endtask

    task automatic set_random_d();
        i_addr_d = $urandom & 32'hFFFF_FFFC;
        i_data_d = $urandom;
        if ($urandom_range(0, 1) == 1) begin
            i_we_d = 4'($urandom_range(1, 15));
            i_rd_d = 1'($urandom_range(0, 1));
        end else begin
            i_we_d = 4'b0000;
            i_rd_d = 1'b1;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; tick(); tick();
        checks++; if ({o_mem_req, o_valid_i, o_valid_d, o_err} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 0000", {o_mem_req, o_valid_i, o_valid_d, o_err}); end
        checks++; if ({o_mem_addr, o_mem_we, o_mem_wdata} !== 68'h0) begin errors++; $display("[TB] FAIL reset_mem_bus: got %h expected 0", {o_mem_addr, o_mem_we, o_mem_wdata}); end
        checks++; if ({o_data_i, o_data_d} !== 64'h0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0", {o_data_i, o_data_d}); end
        rst = 0; tick();
        checks++; if ({o_mem_req, o_valid_i, o_valid_d} !== 3'b000) begin errors++; $display("[TB] FAIL reset_release_idle: got %b expected 000", {o_mem_req, o_valid_i, o_valid_d}); end
    endtask

    task automatic test_i_only();
        do_reset();
        i_req_i = 1; i_addr_i = 32'h100;
        tick();
        checks++; if ({o_mem_req, o_mem_addr, o_mem_we, o_valid_i} !== {1'b1, 32'h100, 4'b0000, 1'b0}) begin errors++; $display("[TB] FAIL ionly_request: got %h expected %h", {o_mem_req, o_mem_addr, o_mem_we, o_valid_i}, {1'b1, 32'h100, 4'b0000, 1'b0}); end
        i_mem_ack = 1; i_mem_rdata = 32'hDEADBEEF;
        tick();
        i_mem_ack = 0; i_req_i = 0;
        checks++; if ({o_valid_i, o_valid_d, o_err, o_mem_req} !== 4'b1000) begin errors++; $display("[TB] FAIL ionly_valid: got %b expected 1000", {o_valid_i, o_valid_d, o_err, o_mem_req}); end
        checks++; if (o_data_i !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL ionly_data: got %h expected deadbeef", o_data_i); end
        tick();
        checks++; if ({o_valid_i, o_mem_req} !== 2'b00) begin errors++; $display("[TB] FAIL ionly_single_pulse: got %b expected 00", {o_valid_i, o_mem_req}); end
    endtask

    task automatic test_d_write();
        do_reset();
        i_we_d = 4'b0011; i_rd_d = 1; i_addr_d = 32'h2004; i_data_d = 32'h12345678;
        tick();
        checks++; if ({o_mem_req, o_mem_addr, o_mem_we, o_mem_wdata} !== {1'b1, 32'h2004, 4'b0011, 32'h12345678}) begin errors++; $display("[TB] FAIL dwrite_request: got %h expected %h", {o_mem_req, o_mem_addr, o_mem_we, o_mem_wdata}, {1'b1, 32'h2004, 4'b0011, 32'h12345678}); end
        i_mem_ack = 1; i_mem_rdata = 32'hFFFFFFFF;
        tick();
        i_mem_ack = 0; i_we_d = 0; i_rd_d = 0;
        checks++; if ({o_valid_d, o_valid_i, o_err} !== 3'b100) begin errors++; $display("[TB] FAIL dwrite_valid: got %b expected 100", {o_valid_d, o_valid_i, o_err}); end
        checks++; if (o_data_d !== 32'h0) begin errors++; $display("[TB] FAIL dwrite_data_kept: got %h expected 00000000", o_data_d); end
    endtask

    task automatic test_contention();
        logic got[$];
        logic exp_d;
        int cyc;
        do_reset();
        i_req_i = 1; i_addr_i = 32'h400; i_rd_d = 1; i_addr_d = 32'h800;
        cyc = 0;
        while (got.size() < 10 && cyc < 200) begin
            tick(); cyc++;
            if (o_valid_d) got.push_back(1'b1);
            if (o_valid_i) got.push_back(1'b0);
            i_mem_ack = o_mem_req;
            i_mem_rdata = $urandom;
        end
        idle_inputs();
        checks++; if (got.size() != 10) begin errors++; $display("[TB] FAIL contention_count: got %0d grants expected 10", got.size()); end
        for (int k = 0; k < got.size() && k < 10; k++) begin
            exp_d = ((k % (MAX_D + 1)) != MAX_D);
            checks++; if (got[k] !== exp_d) begin errors++; $display("[TB] FAIL contention_order[%0d]: got %s expected %s", k, got[k] ? "D" : "I", exp_d ? "D" : "I"); end
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        i_rd_d = 1; i_addr_d = 32'h3000;
        tick();
        for (int c = 1; c <= 8; c++) begin
            checks++; if ({o_mem_req, o_mem_addr, o_mem_we, o_valid_d, o_err} !== {1'b1, 32'h3000, 4'b0000, 1'b0, 1'b0}) begin errors++; $display("[TB] FAIL wait_hold[%0d]: got %h expected %h", c, {o_mem_req, o_mem_addr, o_mem_we, o_valid_d, o_err}, {1'b1, 32'h3000, 4'b0000, 1'b0, 1'b0}); end
            if (c == 8) begin i_mem_ack = 1; i_mem_rdata = 32'hA1B2C3D4; end
            tick();
        end
        i_mem_ack = 0; i_rd_d = 0;
        checks++; if ({o_valid_d, o_err, o_data_d} !== {1'b1, 1'b0, 32'hA1B2C3D4}) begin errors++; $display("[TB] FAIL wait_done: got %h expected %h", {o_valid_d, o_err, o_data_d}, {1'b1, 1'b0, 32'hA1B2C3D4}); end
        tick();
        checks++; if (o_valid_d !== 1'b0) begin errors++; $display("[TB] FAIL wait_single_pulse: got %b expected 0", o_valid_d); end
    endtask

    task automatic test_timeout();
        int n;
        int busy;
        do_reset();
        i_rd_d = 1; i_addr_d = 32'h40;
        tick();
        i_mem_ack = 1; i_mem_rdata = 32'h55AA55AA;
        tick();
        i_mem_ack = 0;
        checks++; if ({o_valid_d, o_data_d} !== {1'b1, 32'h55AA55AA}) begin errors++; $display("[TB] FAIL timeout_preload: got %h expected %h", {o_valid_d, o_data_d}, {1'b1, 32'h55AA55AA}); end
        i_addr_d = 32'h44;
        n = 0;
        tick();
        while (!o_mem_req && n < 4) begin tick(); n++; end
        busy = 0;
        while (o_mem_req && busy < 20) begin busy++; tick(); end
        checks++; if (busy != TMO) begin errors++; $display("[TB] FAIL timeout_busy_cycles: got %0d expected %0d", busy, TMO); end
        checks++; if ({o_valid_d, o_err, o_valid_i, o_data_d} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin errors++; $display("[TB] FAIL timeout_abort: got %h expected %h", {o_valid_d, o_err, o_valid_i, o_data_d}, {1'b1, 1'b1, 1'b0, 32'h0}); end
        i_rd_d = 0;
        tick();
        checks++; if ({o_valid_d, o_err} !== 2'b00) begin errors++; $display("[TB] FAIL timeout_pulse_len: got %b expected 00", {o_valid_d, o_err}); end
    endtask

    task automatic test_reset_mid_busy();
        logic seen_valid;
        do_reset();
        i_req_i = 1; i_addr_i = 32'h500;
        tick();
        checks++; if (o_mem_req !== 1'b1) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 1", o_mem_req); end
        #2 rst = 1;
        #1;
        checks++; if ({o_mem_req, o_valid_i, o_valid_d} !== 3'b000) begin errors++; $display("[TB] FAIL midrst_immediate: got %b expected 000", {o_mem_req, o_valid_i, o_valid_d}); end
        i_req_i = 0;
        tick(); tick();
        rst = 0;
        seen_valid = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            seen_valid = seen_valid | o_valid_i | o_valid_d | o_mem_req;
        end
        checks++; if (seen_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_no_valid: got %b expected 0", seen_valid); end
        i_rd_d = 1; i_addr_d = 32'h600;
        tick();
        checks++; if ({o_mem_req, o_mem_addr} !== {1'b1, 32'h600}) begin errors++; $display("[TB] FAIL midrst_next_req: got %h expected %h", {o_mem_req, o_mem_addr}, {1'b1, 32'h600}); end
        i_mem_ack = 1; i_mem_rdata = 32'h0BADCAFE;
        tick();
        i_mem_ack = 0; i_rd_d = 0;
        checks++; if ({o_valid_d, o_err, o_data_d} !== {1'b1, 1'b0, 32'h0BADCAFE}) begin errors++; $display("[TB] FAIL midrst_next_done: got %h expected %h", {o_valid_d, o_err, o_data_d}, {1'b1, 1'b0, 32'h0BADCAFE}); end
    endtask

    task automatic test_random();
        logic        pend_i, pend_d, exp_d, exp_tmo;
        int          d_left, streak_m, delay, n;
        logic [31:0] model_i, model_d, exp_addr, exp_wdata, rd;
        logic [3:0]  exp_we;
        do_reset();
        streak_m = 0; model_i = 0; model_d = 0;
        for (int r = 0; r < 30; r++) begin
            pend_i = 1'($urandom_range(0, 1));
            pend_d = 1'($urandom_range(0, 1));
            if (!pend_i && !pend_d) pend_d = 1'b1;
            d_left = pend_d ? $urandom_range(1, 6) : 0;
            i_req_i = pend_i;
            i_addr_i = $urandom & 32'hFFFF_FFFC;
            if (pend_d) set_random_d();
            while (pend_i || pend_d) begin
                exp_d = pend_d && (!pend_i || streak_m < MAX_D);
                if (exp_d && pend_i) streak_m++; else streak_m = 0;
                exp_addr  = exp_d ? i_addr_d : i_addr_i;
                exp_we    = exp_d ? i_we_d : 4'b0000;
                exp_wdata = i_data_d;
                n = 0;
                tick();
                while (!o_mem_req && n < 4) begin tick(); n++; end
                checks++; if ({o_mem_req, o_mem_addr, o_mem_we} !== {1'b1, exp_addr, exp_we}) begin errors++; $display("[TB] FAIL rand_grant[%0d]: got %h expected %h", r, {o_mem_req, o_mem_addr, o_mem_we}, {1'b1, exp_addr, exp_we}); end
                if (exp_d && exp_we != 4'b0000) begin
                    checks++; if (o_mem_wdata !== exp_wdata) begin errors++; $display("[TB] FAIL rand_wdata[%0d]: got %h expected %h", r, o_mem_wdata, exp_wdata); end
                end
                delay = $urandom_range(0, 9);
                exp_tmo = (delay >= TMO);
                rd = $urandom;
                if (!exp_tmo) begin
                    repeat (delay) tick();
                    i_mem_ack = 1; i_mem_rdata = rd;
                    tick();
                    i_mem_ack = 0;
                end else begin
                    repeat (TMO) tick();
                end
                if (exp_tmo) begin
                    if (exp_d) model_d = 0; else model_i = 0;
                end else if (!exp_d) begin
                    model_i = rd;
                end else if (exp_we == 4'b0000) begin
                    model_d = rd;
                end
                checks++; if ({o_valid_i, o_valid_d, o_err, o_mem_req, o_data_i, o_data_d} !== {!exp_d, exp_d, exp_tmo, 1'b0, model_i, model_d}) begin errors++; $display("[TB] FAIL rand_done[%0d]: got %h expected %h", r, {o_valid_i, o_valid_d, o_err, o_mem_req, o_data_i, o_data_d}, {!exp_d, exp_d, exp_tmo, 1'b0, model_i, model_d}); end
                if (exp_d) begin
                    d_left--;
                    if (d_left > 0) set_random_d();
                    else begin i_rd_d = 0; i_we_d = 0; pend_d = 0; end
                end else begin
                    i_req_i = 0; pend_i = 0;
                end
            end
            tick();
            checks++; if ({o_valid_i, o_valid_d, o_mem_req} !== 3'b000) begin errors++; $display("[TB] FAIL rand_quiet[%0d]: got %b expected 000", r, {o_valid_i, o_valid_d, o_mem_req}); end
        end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_i_only();
        test_d_write();
        test_contention();
        test_wait_states();
        test_timeout();
        test_reset_mid_busy();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
